// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data RAM port arbiter: data width, RISC-V
// load/store funct3 codes, arbiter states and port identifiers.
package mem_port_arbiter_pkg;

    localparam int MXLEN = 32;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Bytes touched by an access; illegal codes are rejected elsewhere.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3)
            3'd0, 3'd4: access_size = 3'd1;
            3'd1, 3'd5: access_size = 3'd2;
            default:    access_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational fault check for a single RAM access: illegal funct3,
// misalignment, or any byte falling outside 0..RAM_BYTES-1.
module mem_access_check
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned RAM_BYTES = 1024
) (
    input  logic [MXLEN-1:0] i_addr,
    input  logic             i_we,
    input  logic [2:0]       i_funct3,
    output logic             o_err
);

    localparam logic [MXLEN:0] LP_RAM_END = (MXLEN+1)'(RAM_BYTES);

    logic [MXLEN:0] w_end;
    logic           w_illegal;
    logic           w_misaligned;
    logic           w_out_of_range;

    always_comb begin
        if (i_we) begin
            w_illegal = !(i_funct3 inside {F3_SB, F3_SH, F3_SW});
        end else begin
            w_illegal = !(i_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end

        w_misaligned = 1'b0;
        case (i_funct3)
            F3_LH, F3_LHU: w_misaligned = i_addr[0];
            F3_LW:         w_misaligned = |i_addr[1:0];
            default:       w_misaligned = 1'b0;
        endcase

        // One extra bit so an address near the top of the space wraps into a fault.
        w_end          = {1'b0, i_addr} + {{(MXLEN-2){1'b0}}, access_size(i_funct3)};
        w_out_of_range = w_end > LP_RAM_END;

        o_err = w_illegal | w_misaligned | w_out_of_range;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed RAM between instruction fetch and load/store:
// arbitrates, drives the RAM for one cycle, and returns a registered response.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned RAM_BYTES  = 1024,
    parameter logic [3:0]  STARVE_MAX = 4'd4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [MXLEN-1:0] if_addr,
    output logic             if_rsp_valid,
    input  logic             if_rsp_ready,
    output logic [MXLEN-1:0] if_rsp_data,
    output logic             if_rsp_err,
    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic             d_we,
    input  logic [2:0]       d_funct3,
    input  logic [MXLEN-1:0] d_addr,
    input  logic [MXLEN-1:0] d_wdata,
    output logic             d_rsp_valid,
    input  logic             d_rsp_ready,
    output logic [MXLEN-1:0] d_rsp_data,
    output logic             d_rsp_err,
    output logic [MXLEN-1:0] ram_addr,
    output logic [MXLEN-1:0] ram_wdata,
    output logic             ram_load,
    output logic [2:0]       ram_load_ops,
    output logic             ram_store,
    output logic [2:0]       ram_store_ops,
    input  logic [MXLEN-1:0] ram_rdata
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_port;
    logic [MXLEN-1:0] r_addr;
    logic             r_we;
    logic [2:0]       r_funct3;
    logic [MXLEN-1:0] r_wdata;
    logic [3:0]       r_starve;
    logic [MXLEN-1:0] r_rsp_data;
    logic             r_rsp_err;

    logic w_if_wins;
    logic w_if_acc;
    logic w_d_acc;
    logic w_rsp_ready;
    logic w_err;

    mem_access_check #(
        .RAM_BYTES(RAM_BYTES)
    ) u_check (
        .i_addr  (r_addr),
        .i_we    (r_we),
        .i_funct3(r_funct3),
        .o_err   (w_err)
    );

    always_comb begin
        // Fetch takes the slot when data is absent or fetch has waited long enough.
        w_if_wins    = if_req_valid && ((r_starve == STARVE_MAX) || !d_req_valid);
        if_req_ready = (r_state == IDLE) && w_if_wins;
        d_req_ready  = (r_state == IDLE) && d_req_valid && !w_if_wins;
        w_if_acc     = if_req_valid && if_req_ready;
        w_d_acc      = d_req_valid && d_req_ready;
        w_rsp_ready  = (r_port == PORT_D) ? d_rsp_ready : if_rsp_ready;

        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_if_acc || w_d_acc) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    if (w_rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        ram_addr      = '0;
        ram_wdata     = '0;
        ram_load      = 1'b0;
        ram_load_ops  = 3'd0;
        ram_store     = 1'b0;
        ram_store_ops = 3'd0;
        if ((r_state == ACCESS) && !w_err) begin
            ram_addr      = r_addr;
            ram_wdata     = r_wdata;
            ram_load      = !r_we;
            ram_load_ops  = r_funct3;
            ram_store     = r_we;
            ram_store_ops = r_funct3;
        end

        if_rsp_valid = (r_state == RESP) && (r_port == PORT_IF);
        d_rsp_valid  = (r_state == RESP) && (r_port == PORT_D);
        if_rsp_data  = r_rsp_data;
        d_rsp_data   = r_rsp_data;
        if_rsp_err   = r_rsp_err;
        d_rsp_err    = r_rsp_err;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_port     <= PORT_IF;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_funct3   <= 3'd0;
            r_wdata    <= '0;
            r_starve   <= 4'd0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_if_acc) begin
                r_port   <= PORT_IF;
                r_addr   <= if_addr;
                r_we     <= 1'b0;
                r_funct3 <= F3_LW;
                r_wdata  <= '0;
                r_starve <= 4'd0;
            end else if (w_d_acc) begin
                r_port   <= PORT_D;
                r_addr   <= d_addr;
                r_we     <= d_we;
                r_funct3 <= d_funct3;
                r_wdata  <= d_wdata;
                if (if_req_valid && (r_starve != STARVE_MAX)) begin
                    r_starve <= r_starve + 4'd1;
                end
            end
            if (r_state == ACCESS) begin
                r_rsp_data <= r_we ? '0 : ram_rdata;
                r_rsp_err  <= w_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: byte-array RAM model plus a
// reference memory/fault/arbitration model driven by directed and random traffic.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int RB = 1024;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [31:0] if_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata, d_rsp_data;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_load, ram_store;
    logic [2:0]  ram_load_ops, ram_store_ops;

    int compared = 0;
    int mismatched = 0;
    int store_cycles = 0;
    int load_cycles = 0;
    int ref_starve = 0;

    logic [7:0] ram_mem [0:RB-1];
    logic [7:0] ref_mem [0:RB-1];
    bit         mem_init_done = 1'b0;
    logic [9:0] ra;
    logic [141:0] outs;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .RAM_BYTES (1024),
        .STARVE_MAX(4'd4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
        .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_load(ram_load),
        .ram_load_ops(ram_load_ops), .ram_store(ram_store),
        .ram_store_ops(ram_store_ops), .ram_rdata(ram_rdata)
    );

    assign outs = {if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
                   d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
                   ram_addr, ram_wdata, ram_load, ram_load_ops, ram_store, ram_store_ops};

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 151 + 29) ^ (i >> 3));
    endfunction

    // RAM model: combinational formatted read, byte-lane write on the clock edge.
    assign ra = ram_addr[9:0];
    always_comb begin
        ram_rdata = 32'h0;
        if (ram_load) begin
            case (ram_load_ops)
                3'd0: ram_rdata = {{24{ram_mem[ra][7]}}, ram_mem[ra]};
                3'd1: ram_rdata = {{16{ram_mem[ra+10'd1][7]}}, ram_mem[ra+10'd1], ram_mem[ra]};
                3'd2: ram_rdata = {ram_mem[ra+10'd3], ram_mem[ra+10'd2], ram_mem[ra+10'd1], ram_mem[ra]};
                3'd4: ram_rdata = {24'h0, ram_mem[ra]};
                3'd5: ram_rdata = {16'h0, ram_mem[ra+10'd1], ram_mem[ra]};
                default: ram_rdata = 32'h0;
            endcase
        end
    end

    always @(posedge CLK) begin
        if (!mem_init_done) begin
            for (int i = 0; i < RB; i++) ram_mem[i] <= init_byte(i);
            mem_init_done <= 1'b1;
        end else if (ram_store) begin
            ram_mem[ra] <= ram_wdata[7:0];
            if (ram_store_ops != 3'd0) ram_mem[ra+10'd1] <= ram_wdata[15:8];
            if (ram_store_ops == 3'd2) begin
                ram_mem[ra+10'd2] <= ram_wdata[23:16];
                ram_mem[ra+10'd3] <= ram_wdata[31:24];
            end
        end
    end

    always @(negedge CLK) begin
        if (ram_store) store_cycles++;
        if (ram_load) load_cycles++;
    end

    // ---------------- reference model ----------------
    function automatic int unsigned acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit exp_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int unsigned n = acc_size(f3);
        longint unsigned last = {32'h0, a} + 64'(n);
        bit legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
        if (!legal) return 1'b1;
        if ((a % n) != 0) return 1'b1;
        return last > 64'(RB);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
        int i = int'(a[9:0]);
        logic [7:0] b0 = ref_mem[i];
        logic [7:0] b1 = ref_mem[(i + 1) % RB];
        logic [7:0] b2 = ref_mem[(i + 2) % RB];
        logic [7:0] b3 = ref_mem[(i + 3) % RB];
        case (f3)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd2:    return {b3, b2, b1, b0};
            3'd4:    return {24'h0, b0};
            3'd5:    return {16'h0, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int unsigned n = acc_size(f3);
        int i = int'(a[9:0]);
        for (int k = 0; k < int'(n); k++) ref_mem[(i + k) % RB] = wd[8*k +: 8];
    endfunction

    // ---------------- driver (observes only; tests compare) ----------------
    task automatic run_txn(input logic port, input bit we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int hold,
                           output bit accepted, output bit lat_ok, output bit quiet_ok,
                           output bit stable_ok, output logic [31:0] data, output logic err,
                           output bit acc_load, output bit acc_store);
        int n = 0;
        accepted = 0; lat_ok = 0; quiet_ok = 1; stable_ok = 1;
        data = 32'h0; err = 1'b0; acc_load = 0; acc_store = 0;
        if (port == PORT_D) begin
            d_req_valid = 1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
            d_rsp_ready = (hold == 0);
        end else begin
            if_req_valid = 1; if_addr = a; if_rsp_ready = (hold == 0);
        end
        #1;
        while (!(port == PORT_D ? d_req_ready : if_req_ready) && n < 30) begin
            @(negedge CLK); #1; n++;
        end
        if (!(port == PORT_D ? d_req_ready : if_req_ready)) begin
            if (port == PORT_D) d_req_valid = 0; else if_req_valid = 0;
            d_rsp_ready = 1; if_rsp_ready = 1;
            return;
        end
        accepted = 1;
        if (port == PORT_D) begin
            if (if_req_valid && ref_starve < 4) ref_starve++;
        end else begin
            ref_starve = 0;
        end
        @(negedge CLK); #1;
        if (port == PORT_D) d_req_valid = 0; else if_req_valid = 0;
        acc_load = ram_load; acc_store = ram_store;
        lat_ok = !(port == PORT_D ? d_rsp_valid : if_rsp_valid);
        if ((port == PORT_D ? (if_rsp_valid || if_req_ready) : (d_rsp_valid || d_req_ready))) quiet_ok = 0;
        @(negedge CLK); #1;
        lat_ok = lat_ok && (port == PORT_D ? d_rsp_valid : if_rsp_valid);
        if ((port == PORT_D ? (if_rsp_valid || if_req_ready) : (d_rsp_valid || d_req_ready))) quiet_ok = 0;
        data = (port == PORT_D) ? d_rsp_data : if_rsp_data;
        err  = (port == PORT_D) ? d_rsp_err : if_rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK); #1;
            if (port == PORT_D) begin
                if (!d_rsp_valid || d_rsp_data !== data || d_rsp_err !== err) stable_ok = 0;
                if (if_req_ready || if_rsp_valid) quiet_ok = 0;
            end else begin
                if (!if_rsp_valid || if_rsp_data !== data || if_rsp_err !== err) stable_ok = 0;
                if (d_req_ready || d_rsp_valid) quiet_ok = 0;
            end
        end
        d_rsp_ready = 1; if_rsp_ready = 1;
        @(negedge CLK); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        compared++;
        if (outs !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
    endtask

    task automatic test_store_load();
        bit acc, lat, quiet, stab, al, ast;
        logic [31:0] d;
        logic e;
        logic [2:0]  f3s [3] = '{F3_LW, F3_LB, F3_LHU};
        logic [31:0] ads [3] = '{32'h10, 32'h13, 32'h12};
        logic [31:0] exs [3] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h0000DEAD};
        run_txn(PORT_D, 1, F3_SW, 32'h10, 32'hDEADBEEF, 0, acc, lat, quiet, stab, d, e, al, ast);
        ref_store(F3_SW, 32'h10, 32'hDEADBEEF);
        compared++;
        if (!(acc && lat && quiet && ast && e === 1'b0 && d === 32'h0)) begin
            mismatched++;
            $display("FAIL sw_0x10: acc=%0d lat=%0d quiet=%0d store=%0d err=%b data=%h want 1 1 1 1 0 0",
                     acc, lat, quiet, ast, e, d);
        end
        for (int k = 0; k < 3; k++) begin
            run_txn(PORT_D, 0, f3s[k], ads[k], 32'h0, 0, acc, lat, quiet, stab, d, e, al, ast);
            compared++;
            if (!(acc && lat && al && e === 1'b0 && d === exs[k])) begin
                mismatched++;
                $display("FAIL load_%0d addr %h: acc=%0d lat=%0d load=%0d err=%b data=%h want data=%h err=0",
                         k, ads[k], acc, lat, al, e, d, exs[k]);
            end
        end
    endtask

    task automatic test_fetch();
        bit acc, lat, quiet, stab, al, ast;
        logic [31:0] d;
        logic e;
        run_txn(PORT_IF, 0, F3_LW, 32'h10, 32'h0, 0, acc, lat, quiet, stab, d, e, al, ast);
        compared++;
        if (!(acc && lat && quiet && e === 1'b0 && d === 32'hDEADBEEF)) begin
            mismatched++;
            $display("FAIL fetch_0x10: acc=%0d lat=%0d quiet=%0d err=%b data=%h want 1 1 1 0 deadbeef",
                     acc, lat, quiet, e, d);
        end
    endtask

    task automatic test_faults();
        bit acc, lat, quiet, stab, al, ast;
        logic [31:0] d;
        logic e;
        int l0, s0;
        bit          wes [5] = '{0, 1, 1, 1, 0};
        logic [2:0]  f3s [5] = '{F3_LW, F3_SH, 3'd4, F3_SW, F3_LW};
        logic [31:0] ads [5] = '{32'h102, 32'h3FF, 32'h100, 32'h3FC, 32'hFFFFFFFC};
        bit          ers [5] = '{1, 1, 1, 0, 1};
        for (int k = 0; k < 5; k++) begin
            logic [31:0] wd = $urandom;
            l0 = load_cycles; s0 = store_cycles;
            run_txn(PORT_D, wes[k], f3s[k], ads[k], wd, 0, acc, lat, quiet, stab, d, e, al, ast);
            compared++;
            if (!(acc && lat && e === ers[k] && e === exp_err(wes[k], f3s[k], ads[k]))) begin
                mismatched++;
                $display("FAIL fault_%0d addr %h f3 %0d: acc=%0d lat=%0d err=%b want err=%0d",
                         k, ads[k], f3s[k], acc, lat, e, ers[k]);
            end
            compared++;
            if ((load_cycles - l0) != ((!wes[k] && !ers[k]) ? 1 : 0) ||
                (store_cycles - s0) != ((wes[k] && !ers[k]) ? 1 : 0)) begin
                mismatched++;
                $display("FAIL fault_ram_ctrl_%0d: load_cycles=%0d store_cycles=%0d",
                         k, load_cycles - l0, store_cycles - s0);
            end
            if (wes[k] && !ers[k]) ref_store(f3s[k], ads[k], wd);
        end
        run_txn(PORT_D, 0, F3_LBU, 32'h3FF, 32'h0, 0, acc, lat, quiet, stab, d, e, al, ast);
        compared++;
        if (!(acc && e === 1'b0 && d === exp_load(F3_LBU, 32'h3FF))) begin
            mismatched++;
            $display("FAIL byte_0x3ff_after_sh: got %h err=%b want %h", d, e, exp_load(F3_LBU, 32'h3FF));
        end
    endtask

    task automatic test_backpressure();
        bit acc, lat, quiet, stab, al, ast;
        logic [31:0] d;
        logic e;
        int s0 = store_cycles;
        if_addr = 32'h10; if_req_valid = 1;
        run_txn(PORT_D, 1, F3_SW, 32'h40, 32'h12345678, 5, acc, lat, quiet, stab, d, e, al, ast);
        if_req_valid = 0;
        ref_store(F3_SW, 32'h40, 32'h12345678);
        compared++;
        if (!(acc && lat && stab && quiet && e === 1'b0 && d === 32'h0 && (store_cycles - s0) == 1)) begin
            mismatched++;
            $display("FAIL backpressure: acc=%0d lat=%0d stable=%0d quiet=%0d err=%b data=%h stores=%0d want 1 1 1 1 0 0 1",
                     acc, lat, stab, quiet, e, d, store_cycles - s0);
        end
    endtask

    task automatic test_contention();
        int grants = 0;
        int last = -1;
        bit dr, fr, want_f;
        d_we = 0; d_funct3 = F3_LW; d_addr = 32'h40; d_req_valid = 1;
        if_addr = 32'h44; if_req_valid = 1;
        d_rsp_ready = 1; if_rsp_ready = 1;
        #1;
        for (int c = 0; c < 60; c++) begin
            dr = d_req_ready; fr = if_req_ready;
            if (dr || fr) begin
                want_f = (ref_starve == 4);
                compared++;
                if (fr !== want_f || dr === fr) begin
                    mismatched++;
                    $display("FAIL contention_grant cycle %0d: d_ready=%0d if_ready=%0d want fetch=%0d",
                             c, dr, fr, want_f);
                end
                if (last >= 0) begin
                    compared++;
                    if (c - last != 3) begin
                        mismatched++;
                        $display("FAIL contention_spacing cycle %0d: gap %0d want 3", c, c - last);
                    end
                end
                last = c;
                grants++;
                if (fr) ref_starve = 0; else if (ref_starve < 4) ref_starve++;
            end
            if (d_rsp_valid) begin
                compared++;
                if (d_rsp_data !== exp_load(F3_LW, 32'h40) || d_rsp_err !== 1'b0) begin
                    mismatched++;
                    $display("FAIL contention_d_data: got %h want %h", d_rsp_data, exp_load(F3_LW, 32'h40));
                end
            end
            if (if_rsp_valid) begin
                compared++;
                if (if_rsp_data !== exp_load(F3_LW, 32'h44) || if_rsp_err !== 1'b0) begin
                    mismatched++;
                    $display("FAIL contention_if_data: got %h want %h", if_rsp_data, exp_load(F3_LW, 32'h44));
                end
            end
            @(negedge CLK); #1;
        end
        d_req_valid = 0; if_req_valid = 0;
        repeat (3) begin @(negedge CLK); #1; end
        compared++;
        if (grants < 18) begin
            mismatched++;
            $display("FAIL contention_progress: grants=%0d want at least 18", grants);
        end
    endtask

    task automatic test_reset_midop();
        bit acc, lat, quiet, stab, al, ast;
        logic [31:0] d;
        logic e;
        int n = 0;
        d_we = 1; d_funct3 = F3_SW; d_addr = 32'h20; d_wdata = 32'hCAFEF00D; d_req_valid = 1;
        #1;
        while (!d_req_ready && n < 30) begin @(negedge CLK); #1; n++; end
        compared++;
        if (!d_req_ready) begin
            mismatched++;
            $display("FAIL reset_midop_accept: d_req_ready=%b want 1", d_req_ready);
        end
        @(negedge CLK); #1;
        d_req_valid = 0;
        compared++;
        if (ram_store !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_midop_access: ram_store=%b want 1", ram_store);
        end
        RST_N = 0;
        #1;
        compared++;
        if (outs !== '0) begin
            mismatched++;
            $display("FAIL reset_midop_async: outputs %h want 0", outs);
        end
        repeat (2) begin @(negedge CLK); #1; end
        compared++;
        if (outs !== '0) begin
            mismatched++;
            $display("FAIL reset_midop_held: outputs %h want 0", outs);
        end
        RST_N = 1;
        ref_starve = 0;
        #1;
        run_txn(PORT_D, 0, F3_LW, 32'h20, 32'h0, 0, acc, lat, quiet, stab, d, e, al, ast);
        compared++;
        if (!(acc && lat && e === 1'b0 && d === exp_load(F3_LW, 32'h20))) begin
            mismatched++;
            $display("FAIL reset_midop_reload: acc=%0d lat=%0d err=%b data=%h want 1 1 0 %h",
                     acc, lat, e, d, exp_load(F3_LW, 32'h20));
        end
    endtask

    task automatic test_random();
        bit acc, lat, quiet, stab, al, ast, we, ee;
        logic [31:0] d, a, wd, ed;
        logic [2:0] f3;
        logic e, port;
        int mode, hold;
        for (int t = 0; t < 40; t++) begin
            port = ($urandom_range(0, 3) == 0) ? PORT_IF : PORT_D;
            we = (port == PORT_D) && ($urandom_range(0, 1) == 1);
            if (port == PORT_IF) f3 = F3_LW;
            else if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            mode = $urandom_range(0, 9);
            a = 32'($urandom_range(0, RB - 1));
            if (mode < 6) a = a & ~32'(acc_size(f3) - 1);
            else if (mode == 7) a = 32'(RB - 4 + $urandom_range(0, 3));
            else if (mode >= 8) a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            wd = $urandom;
            hold = $urandom_range(0, 2);
            ee = exp_err(we, f3, a);
            ed = (!we && !ee) ? exp_load(f3, a) : 32'h0;
            run_txn(port, we, f3, a, wd, hold, acc, lat, quiet, stab, d, e, al, ast);
            compared++;
            if (!acc || !lat || !quiet || !stab || e !== ee || ((we || !ee) && d !== ed)) begin
                mismatched++;
                $display("FAIL random_%0d port=%0d we=%0d f3=%0d addr=%h: acc=%0d lat=%0d quiet=%0d stable=%0d err=%b data=%h want err=%0d data=%h",
                         t, port, we, f3, a, acc, lat, quiet, stab, e, d, ee, ed);
            end
            if (we && !ee) ref_store(f3, a, wd);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_req_valid = 0; if_addr = 0; if_rsp_ready = 1;
        d_req_valid = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0; d_rsp_ready = 1;
        for (int i = 0; i < RB; i++) ref_mem[i] = init_byte(i);
        repeat (2) @(negedge CLK);
        #1;
        test_reset();
        RST_N = 1;
        @(negedge CLK); #1;
        test_store_load();
        test_fetch();
        test_faults();
        test_backpressure();
        test_contention();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
